sine_period_analyzer: RTL and testbench

SINE_PERIOD_ANALYZER -- requirements
Module: sine_period_analyzer

---
 rtl/sine_period_analyzer.sv | 93 +++++++++
 tb/tb_sine_period_analyzer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sine_period_analyzer.sv
// sine_period_analyzer: measures rising-zero-crossing period and signed peaks of a sample stream
module sine_period_analyzer #(
  parameter int MIN_PERIOD = 4,
  parameter int MAX_PERIOD = 255,
  parameter int LOCK_COUNT = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic signed [7:0] sample_in,
  input  logic              sample_valid,
  output logic        [7:0] period,
  output logic signed [7:0] peak_pos,
  output logic signed [7:0] peak_neg,
  output logic              measure_valid,
  output logic              locked,
  output logic              timeout
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  typedef enum logic {SEARCH, MEASURE} state_t;
  state_t            state, state_nx;
  logic        [7:0] cnt, cnt_nx;
  logic signed [7:0] max_q, min_q, max_nx, min_nx;
  logic     [MW-1:0] match_cnt, match_nx;
  logic              prev_neg;
  logic              crossing, meas_ev, to_ev;
  assign crossing = sample_valid & ~sample_in[7] & prev_neg;
  assign meas_ev  = state == MEASURE && crossing && cnt >= 8'(MIN_PERIOD);
  // a short-period crossing is a glitch, so it falls through to the timeout/count path
  assign to_ev    = sample_valid && state == MEASURE && !meas_ev && cnt == 8'(MAX_PERIOD);
  // next-state: arm on first crossing, close periods, count and track peaks, time out
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    max_nx   = max_q;
    min_nx   = min_q;
    match_nx = match_cnt;
    if (sample_valid) begin
      if (state == SEARCH) begin
        if (crossing) begin
          state_nx = MEASURE;
          cnt_nx   = 8'd1;
          max_nx   = sample_in;
          min_nx   = sample_in;
        end
      end else if (meas_ev) begin
        cnt_nx   = 8'd1;
        max_nx   = sample_in;
        min_nx   = sample_in;
        match_nx = (cnt == period) ? ((match_cnt == MW'(LOCK_COUNT)) ? match_cnt : match_cnt + 1'b1) : MW'(1);
      end else if (to_ev) begin
        state_nx = SEARCH;
        cnt_nx   = 8'd0;
        match_nx = '0;
      end else begin
        cnt_nx = cnt + 8'd1;
        max_nx = (sample_in > max_q) ? sample_in : max_q;
        min_nx = (sample_in < min_q) ? sample_in : min_q;
      end
    end
  end
  // state, trackers and result registers; results only move on a completed period
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state         <= SEARCH;
      cnt           <= '0;
      max_q         <= '0;
      min_q         <= '0;
      match_cnt     <= '0;
      prev_neg      <= 1'b0;
      period        <= '0;
      peak_pos      <= '0;
      peak_neg      <= '0;
      measure_valid <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      max_q         <= max_nx;
      min_q         <= min_nx;
      match_cnt     <= match_nx;
      prev_neg      <= sample_valid ? sample_in[7] : prev_neg;
      measure_valid <= meas_ev;
      timeout       <= to_ev;
      locked        <= match_nx >= MW'(LOCK_COUNT);
      if (meas_ev) begin
        period   <= cnt;
        peak_pos <= max_q;
        peak_neg <= min_q;
      end
    end
  end
endmodule

// File: tb/tb_sine_period_analyzer.sv
// tb_sine_period_analyzer: vector table plus scoreboard bench for sine_period_analyzer
module tb_sine_period_analyzer;
  logic              Clk = 1'b0;
  logic              Rst_n;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic        [7:0] period;
  logic signed [7:0] peak_pos, peak_neg;
  logic              measure_valid, locked, timeout;
  always #5 Clk = ~Clk;
  sine_period_analyzer dut (
    .Clk(Clk), .Rst_n(Rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .period(period), .peak_pos(peak_pos), .peak_neg(peak_neg),
    .measure_valid(measure_valid), .locked(locked), .timeout(timeout)
  );
  typedef enum logic [1:0] {EV_NONE, EV_MEAS, EV_TMO, EV_RST} ev_t;
  typedef struct {
    logic rst_n;
    logic valid;
    int   s;
    ev_t  ev;
    int   per;
    int   pp;
    int   pn;
    logic lk;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int t29[29] = '{0, 16, 31, 45, 58, 67, 74, 77, 77, 74, 67, 58, 45, 31, 16, 0,
                  -16, -31, -45, -58, -67, -74, -77, -77, -74, -67, -58, -45, -31};
  function automatic void add(logic r, logic v, int s, ev_t ev = EV_NONE,
                              int per = 0, int pp = 0, int pn = 0, logic lk = 1'b0);
    vec_t x;
    x.rst_n = r; x.valid = v; x.s = s; x.ev = ev;
    x.per = per; x.pp = pp; x.pn = pn; x.lk = lk;
    vecs.push_back(x);
  endfunction
  // one pass (or slice) of the 29- or 30-sample table; the 30-sample table appends -16
  function automatic void play(int len, int from, int to, ev_t ev0, int per, logic lk, bit slow);
    for (int i = from; i <= to; i++) begin
      int s = (i < 29) ? t29[i] : -16;
      if (i == 0) add(1'b1, 1'b1, s, ev0, per, 77, -77, lk);
      else add(1'b1, 1'b1, s);
      if (slow) add(1'b1, 1'b0, (i % 2 == 1) ? 100 : -100);
    end
  endfunction
  task automatic check(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask
  initial begin
    vec_t e;
    Rst_n = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    add(1'b0, 1'b0, 0, EV_RST);
    add(1'b0, 1'b1, -50, EV_RST);
    play(29, 0, 28, EV_NONE, 0, 1'b0, 1'b0);
    play(29, 0, 28, EV_NONE, 0, 1'b0, 1'b0);
    for (int m = 1; m <= 4; m++) play(29, 0, 28, EV_MEAS, 29, m >= 3, 1'b0);
    for (int m = 0; m < 3; m++) play(29, 0, 28, EV_MEAS, 29, 1'b1, 1'b1);
    add(1'b1, 1'b1, 0, EV_MEAS, 29, 77, -77, 1'b1);
    repeat (254) add(1'b1, 1'b1, 20);
    add(1'b1, 1'b1, 20, EV_TMO, 29, 77, -77, 1'b0);
    repeat (5) add(1'b1, 1'b1, 20);
    play(29, 0, 28, EV_NONE, 0, 1'b0, 1'b0);
    play(29, 0, 28, EV_NONE, 0, 1'b0, 1'b0);
    for (int m = 1; m <= 3; m++) play(29, 0, 28, EV_MEAS, 29, m >= 3, 1'b0);
    play(30, 0, 29, EV_MEAS, 29, 1'b1, 1'b0);
    play(30, 0, 29, EV_MEAS, 30, 1'b0, 1'b0);
    play(30, 0, 29, EV_MEAS, 30, 1'b0, 1'b0);
    play(30, 0, 29, EV_MEAS, 30, 1'b1, 1'b0);
    play(30, 0, 10, EV_MEAS, 30, 1'b1, 1'b0);
    add(1'b0, 1'b1, 50, EV_RST);
    play(30, 11, 29, EV_NONE, 0, 1'b0, 1'b0);
    play(29, 0, 28, EV_NONE, 0, 1'b0, 1'b0);
    play(29, 0, 28, EV_MEAS, 29, 1'b0, 1'b0);
    play(29, 0, 28, EV_MEAS, 29, 1'b0, 1'b0);
    add(1'b0, 1'b0, 0, EV_RST);
    add(1'b1, 1'b1, -10);
    add(1'b1, 1'b1, 10);
    add(1'b1, 1'b1, 20);
    add(1'b1, 1'b1, -5);
    add(1'b1, 1'b1, 5);
    repeat (30) add(1'b1, 1'b1, 40);
    add(1'b1, 1'b1, -20);
    add(1'b1, 1'b1, 0, EV_MEAS, 35, 40, -20, 1'b0);
    repeat (253) add(1'b1, 1'b1, 20);
    add(1'b1, 1'b1, -20);
    add(1'b1, 1'b1, 0, EV_MEAS, 255, 20, -20, 1'b0);
    add(1'b1, 1'b1, 10);
    add(1'b1, 1'b1, 10);
    add(1'b1, 1'b1, -10);
    add(1'b1, 1'b1, 10, EV_MEAS, 4, 10, -10, 1'b0);
    add(1'b1, 1'b1, 10);
    add(1'b1, 1'b0, -90);
    for (int i = 0; i < vecs.size(); i++) begin
      Rst_n = vecs[i].rst_n;
      sample_valid = vecs[i].valid;
      sample_in = 8'(vecs[i].s);
      if (vecs[i].ev != EV_NONE) sb.push_back(vecs[i]);
      @(posedge Clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.ev == EV_RST) begin
          check("rst_period", int'(period), 0);
          check("rst_peak_pos", int'(peak_pos), 0);
          check("rst_peak_neg", int'(peak_neg), 0);
          check("rst_pulses", int'({measure_valid, timeout}), 0);
          check("rst_locked", int'(locked), 0);
        end else if (e.ev == EV_MEAS) begin
          check("meas_valid", int'(measure_valid), 1);
          check("meas_no_timeout", int'(timeout), 0);
          check("meas_period", int'(period), e.per);
          check("meas_peak_pos", int'(peak_pos), e.pp);
          check("meas_peak_neg", int'(peak_neg), e.pn);
          check("meas_locked", int'(locked), int'(e.lk));
        end else begin
          check("tmo_pulse", int'(timeout), 1);
          check("tmo_no_meas", int'(measure_valid), 0);
          check("tmo_locked", int'(locked), 0);
          check("tmo_period_held", int'(period), e.per);
          check("tmo_peak_pos_held", int'(peak_pos), e.pp);
          check("tmo_peak_neg_held", int'(peak_neg), e.pn);
        end
      end else begin
        check("no_pulse", int'({measure_valid, timeout}), 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
